// File: rtl/spi_sub_burst_pkg.sv
// Shared types for the burst-capable SPI subordinate: command opcodes and FSM states.
package spi_sub_pkg;

   typedef enum logic [1:0] {
      OP_READ     = 2'b00,
      OP_WRITE    = 2'b01,
      OP_BURST_RD = 2'b10,
      OP_BURST_WR = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      TURN,
      RESP,
      BWR,
      BRD
   } state_e;

endpackage

// File: rtl/spi_sub_burst_if.sv
// SPI pins plus the RAM-style bus of the subordinate, grouped as one interface.
interface spi_sub_burst_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic              cs_n;
   logic              mosi;
   logic              miso;
   logic              r_en;
   logic              w_en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_o;
   logic [DATA_W-1:0] data_i;
   logic              frm_err;

   modport slave (
      input  cs_n, mosi, data_i,
      output miso, r_en, w_en, addr, data_o, frm_err
   );

   modport master (
      output cs_n, mosi, data_i,
      input  miso, r_en, w_en, addr, data_o, frm_err
   );
endinterface

// File: rtl/spi_sub_burst_shreg.sv
// MSB-first shift register with clear/load; exposes only the top OUT_W bits.
module spi_shreg #(
   parameter int W     = 8,
   parameter int OUT_W = W
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [W-1:0]     load_val,
   input  logic             shift,
   input  logic             sin,
   output logic [OUT_W-1:0] q
);
   logic [W-1:0] q_reg;

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         q_reg <= '0;
      end else if (clear) begin
         q_reg <= '0;
      end else if (load) begin
         q_reg <= load_val;
      end else if (shift) begin
         q_reg <= {q_reg[W-2:0], sin};
      end
   end

   assign q = q_reg[W-1 -: OUT_W];
endmodule

// File: rtl/spi_sub_burst.sv
// SPI subordinate bridging single/burst read/write commands onto a RAM-style bus.
module spi_sub_burst
   import spi_sub_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input logic            sclk,
   input logic            rst,
   spi_sub_burst_if.slave bus
);
   localparam int FRAME_W = 2 + ADDR_W + DATA_W;
   localparam int HDR_W   = 2 + ADDR_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] HDR_LAST    = CNT_W'(HDR_W - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] WORD_LAST   = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] WORD_PENULT = CNT_W'(DATA_W - 2);

   state_e            state_reg, state_next;
   op_e               op_reg, op_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] data_reg, data_next;
   logic              r_en_reg, r_en_next;
   logic              w_en_reg, w_en_next;
   logic              err_reg, err_next;

   logic               rx_clr, rx_shift;
   logic [FRAME_W-1:0] rx_q, rx_sh;
   logic               tx_clr, tx_load, tx_shift;
   logic [FRAME_W-1:0] tx_val;
   logic               tx_msb;

   spi_shreg #(.W(FRAME_W), .OUT_W(FRAME_W)) u_rx (
      .sclk(sclk), .rst(rst), .clear(rx_clr), .load(1'b0), .load_val('0),
      .shift(rx_shift), .sin(bus.mosi), .q(rx_q)
   );

   spi_shreg #(.W(FRAME_W), .OUT_W(1)) u_tx (
      .sclk(sclk), .rst(rst), .clear(tx_clr), .load(tx_load), .load_val(tx_val),
      .shift(tx_shift), .sin(1'b0), .q(tx_msb)
   );

   // Receive register as it will be after this edge's shift.
   assign rx_sh = {rx_q[FRAME_W-2:0], bus.mosi};

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         op_reg    <= OP_READ;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         data_reg  <= '0;
         r_en_reg  <= 1'b0;
         w_en_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         cnt_reg   <= cnt_next;
         addr_reg  <= addr_next;
         data_reg  <= data_next;
         r_en_reg  <= r_en_next;
         w_en_reg  <= w_en_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      cnt_next   = cnt_reg;
      addr_next  = addr_reg;
      data_next  = data_reg;
      r_en_next  = 1'b0;
      w_en_next  = 1'b0;
      err_next   = 1'b0;
      rx_clr     = 1'b0;
      rx_shift   = 1'b0;
      tx_clr     = 1'b0;
      tx_load    = 1'b0;
      tx_shift   = 1'b0;
      tx_val     = '0;
      if (bus.cs_n) begin
         state_next = IDLE;
         cnt_next   = '0;
         rx_clr     = 1'b1;
         tx_clr     = 1'b1;
         err_next   = (state_reg == CMD || state_reg == BWR) && (cnt_reg != '0);
      end else begin
         case (state_reg)
            IDLE: begin
               state_next = CMD;
               rx_shift   = 1'b1;
               cnt_next   = CNT_W'(1);
            end
            CMD: begin
               rx_shift = 1'b1;
               cnt_next = cnt_reg + 1'b1;
               // op[1] of a burst header sits one below the newest bit after HDR_W-1 bits.
               if (cnt_reg == HDR_LAST && rx_q[HDR_W-2]) begin
                  state_next = TURN;
                  cnt_next   = '0;
                  op_next    = op_e'(rx_sh[HDR_W-1 -: 2]);
                  addr_next  = rx_sh[ADDR_W-1:0];
                  r_en_next  = (op_next == OP_BURST_RD);
               end else if (cnt_reg == FRAME_LAST) begin
                  state_next = TURN;
                  cnt_next   = '0;
                  op_next    = op_e'(rx_sh[FRAME_W-1 -: 2]);
                  addr_next  = rx_sh[DATA_W +: ADDR_W];
                  if (op_next == OP_WRITE) begin
                     w_en_next = 1'b1;
                     data_next = rx_sh[DATA_W-1:0];
                  end else begin
                     r_en_next = 1'b1;
                  end
               end
            end
            TURN: begin
               cnt_next = '0;
               case (op_reg)
                  OP_READ: begin
                     state_next = RESP;
                     tx_load    = 1'b1;
                     tx_val     = {rx_q[FRAME_W-1:DATA_W], bus.data_i};
                  end
                  OP_WRITE: begin
                     state_next = RESP;
                     tx_load    = 1'b1;
                     tx_val     = rx_q;
                  end
                  OP_BURST_WR: state_next = BWR;
                  default: begin
                     state_next = BRD;
                     tx_load    = 1'b1;
                     tx_val     = {bus.data_i, {HDR_W{1'b0}}};
                  end
               endcase
            end
            RESP: begin
               tx_shift = 1'b1;
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == FRAME_LAST) begin
                  state_next = CMD;
                  cnt_next   = '0;
               end
            end
            BWR: begin
               rx_shift = 1'b1;
               if (w_en_reg) begin
                  addr_next = addr_reg + 1'b1;
               end
               if (cnt_reg == WORD_LAST) begin
                  cnt_next  = '0;
                  w_en_next = 1'b1;
                  data_next = rx_sh[DATA_W-1:0];
                  tx_load   = 1'b1;
                  tx_val    = {rx_sh[DATA_W-1:0], {HDR_W{1'b0}}};
               end else begin
                  cnt_next = cnt_reg + 1'b1;
                  tx_shift = 1'b1;
               end
            end
            BRD: begin
               cnt_next = cnt_reg + 1'b1;
               tx_shift = 1'b1;
               // Prefetch the next word during the current word's last bit.
               if (cnt_reg == WORD_PENULT) begin
                  r_en_next = 1'b1;
                  addr_next = addr_reg + 1'b1;
               end
               if (cnt_reg == WORD_LAST) begin
                  cnt_next = '0;
                  tx_shift = 1'b0;
                  tx_load  = 1'b1;
                  tx_val   = {bus.data_i, {HDR_W{1'b0}}};
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign bus.miso    = tx_msb;
   assign bus.r_en    = r_en_reg;
   assign bus.w_en    = w_en_reg;
   assign bus.addr    = addr_reg;
   assign bus.data_o  = data_reg;
   assign bus.frm_err = err_reg;
endmodule

// File: tb/tb_spi_sub_burst.sv
// Bench for spi_sub_burst: SPI master tasks, combinational-read RAM and write/response scoreboards.
module tb_spi_sub_burst;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 10;
   localparam int FRAME_W = 2 + ADDR_W + DATA_W;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   logic sclk = 1'b0;
   logic rst  = 1'b1;
   always #5 sclk = ~sclk;

   spi_sub_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   spi_sub_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .sclk(sclk),
      .rst (rst),
      .bus (bus)
   );

   logic [DATA_W-1:0] mem     [1024];
   logic [DATA_W-1:0] ref_mem [1024];
   wr_t               wr_q[$];
   logic [63:0]       exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int n_wen   = 0;
   int n_ren   = 0;
   int n_err   = 0;

   assign bus.data_i = bus.r_en ? mem[bus.addr] : '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitor: writes are popped from the scoreboard and applied to the RAM.
   always @(negedge sclk) begin
      wr_t e;
      if (!rst) begin
         if (bus.w_en && bus.r_en) check_val("strobe_excl", 64'(1), 64'(0));
         if (bus.w_en) begin
            n_wen <= n_wen + 1;
            if (wr_q.size() == 0) begin
               check_val("wen_unexpected", 64'(1), 64'(0));
            end else begin
               e = wr_q.pop_front();
               check_val("wen_addr", 64'(bus.addr), 64'(e.a));
               check_val("wen_data", 64'(bus.data_o), 64'(e.d));
            end
            mem[bus.addr] <= bus.data_o;
         end
         if (bus.r_en)    n_ren <= n_ren + 1;
         if (bus.frm_err) n_err <= n_err + 1;
      end
   end

   task automatic cyc(input logic cs, input logic b, output logic m);
      @(negedge sclk);
      m = bus.miso;
      bus.cs_n = cs;
      bus.mosi = b;
   endtask

   task automatic send_bits(input logic [63:0] v, input int n, output logic [63:0] echo);
      logic m;
      echo = '0;
      for (int i = n - 1; i >= 0; i--) begin
         cyc(1'b0, v[i], m);
         echo = {echo[62:0], m};
      end
   endtask

   task automatic recv_bits(input int n, output logic [63:0] r);
      logic m;
      r = '0;
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 1'bx, m);
         r = {r[62:0], m};
      end
   endtask

   task automatic turn_cycle();
      logic m;
      cyc(1'b0, 1'bx, m);
      check_val("turn_miso", 64'(m), 64'(0));
   endtask

   task automatic end_frame();
      logic m;
      cyc(1'b1, 1'b0, m);
      cyc(1'b1, 1'b0, m);
   endtask

   task automatic single(input logic [1:0] op, input logic [ADDR_W-1:0] a_v, input logic [DATA_W-1:0] d_v);
      logic [FRAME_W-1:0] f;
      logic [63:0] dmy, rsp;
      f = {op, a_v, d_v};
      if (op == 2'b01) begin
         wr_q.push_back({a_v, d_v});
         ref_mem[a_v] = d_v;
         exp_q.push_back(64'(f));
      end else begin
         exp_q.push_back(64'({op, a_v, ref_mem[a_v]}));
      end
      send_bits(64'(f), FRAME_W, dmy);
      turn_cycle();
      recv_bits(FRAME_W, rsp);
      check_val("resp_frame", rsp, exp_q.pop_front());
      $display("[TB] %s addr=0x%03h resp=0x%011h", (op == 2'b01) ? "WRITE" : "READ", a_v, rsp);
   endtask

   task automatic bwr(input logic [ADDR_W-1:0] a_v, input int n, input logic [3:0][DATA_W-1:0] ws);
      logic [63:0] dmy, echo;
      logic [DATA_W-1:0] prev;
      logic [ADDR_W-1:0] a;
      prev = '0;
      send_bits(64'({2'b11, a_v}), 2 + ADDR_W, dmy);
      turn_cycle();
      for (int k = 0; k < n; k++) begin
         a = a_v + ADDR_W'(k);
         wr_q.push_back({a, ws[k]});
         ref_mem[a] = ws[k];
         exp_q.push_back(64'(prev));
         send_bits(64'(ws[k]), DATA_W, echo);
         check_val("bwr_echo", echo, exp_q.pop_front());
         $display("[TB] BURST_WR word %0d addr=0x%03h data=0x%08h echo=0x%08h", k, a, ws[k], echo);
         prev = ws[k];
      end
      end_frame();
   endtask

   task automatic brd(input logic [ADDR_W-1:0] a_v, input int n);
      logic [63:0] dmy, r;
      logic [ADDR_W-1:0] a;
      send_bits(64'({2'b10, a_v}), 2 + ADDR_W, dmy);
      turn_cycle();
      for (int k = 0; k < n; k++) begin
         a = a_v + ADDR_W'(k);
         exp_q.push_back(64'(ref_mem[a]));
         recv_bits(DATA_W, r);
         check_val("brd_word", r, exp_q.pop_front());
         $display("[TB] BURST_RD word %0d addr=0x%03h data=0x%08h", k, a, r);
      end
      end_frame();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic m;
      logic [63:0] dmy;
      logic [FRAME_W-1:0] f;
      logic [3:0][DATA_W-1:0] ws;
      int ren0, wen0, err0;

      for (int i = 0; i < 1024; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      repeat (3) @(negedge sclk);
      check_val("reset_outputs",
                64'({bus.miso, bus.r_en, bus.w_en, bus.frm_err, bus.addr, bus.data_o}), 64'(0));
      rst = 1'b0;
      @(negedge sclk);

      // 1: single write, echoed response
      single(2'b01, 10'h035, 32'hCAFEBABE);
      end_frame();

      // 2: back-to-back write then read with cs_n held low
      single(2'b01, 10'h034, 32'hCAFEBABE);
      #1 ren0 = n_ren;
      single(2'b00, 10'h034, 32'h0);
      #1 check_val("read_ren_count", 64'(n_ren - ren0), 64'(1));
      end_frame();

      // 3: burst write wrapping past the top of the address space
      ws = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      bwr(10'h3FE, 4, ws);

      // 4: burst read across the wrap
      #1 ren0 = n_ren;
      brd(10'h3FF, 3);
      #1 check_val("brd_ren_count", 64'(n_ren - ren0), 64'(4));

      // 5: truncated write frame
      #1 begin wen0 = n_wen; err0 = n_err; end
      f = {2'b01, 10'h200, 32'h12345678};
      for (int i = FRAME_W - 1; i >= FRAME_W - 20; i--) cyc(1'b0, f[i], m);
      cyc(1'b1, 1'b0, m);
      cyc(1'b1, 1'b0, m);
      cyc(1'b1, 1'b0, m);
      #1 check_val("trunc_frm_err", 64'(n_err - err0), 64'(1));
      check_val("trunc_no_wen", 64'(n_wen - wen0), 64'(0));
      check_val("trunc_miso", 64'(bus.miso), 64'(0));
      $display("[TB] truncated WRITE after 20 bits");
      single(2'b01, 10'h200, 32'h12345678);
      end_frame();
      check_val("after_trunc_mem", 64'(mem[10'h200]), 64'(32'h12345678));

      // 6: reset in the middle of burst word 2
      ws = {32'h0, 32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0};
      send_bits(64'({2'b11, 10'h100}), 2 + ADDR_W, dmy);
      turn_cycle();
      for (int k = 0; k < 2; k++) begin
         wr_q.push_back({10'h100 + 10'(k), ws[k]});
         ref_mem[10'h100 + 10'(k)] = ws[k];
         send_bits(64'(ws[k]), DATA_W, dmy);
      end
      for (int i = DATA_W - 1; i >= DATA_W - 10; i--) cyc(1'b0, ws[2][i], m);
      #2 rst = 1'b1;
      #1 check_val("midreset_outputs",
                   64'({bus.miso, bus.r_en, bus.w_en, bus.frm_err, bus.addr, bus.data_o}), 64'(0));
      bus.cs_n = 1'b1;
      repeat (3) @(negedge sclk);
      rst = 1'b0;
      @(negedge sclk);
      $display("[TB] reset during BURST_WR word 2");
      check_val("kept_word0", 64'(mem[10'h100]), 64'(32'hA0A0A0A0));
      check_val("kept_word1", 64'(mem[10'h101]), 64'(32'hB0B0B0B0));
      check_val("no_word2",   64'(mem[10'h102]), 64'(0));
      single(2'b00, 10'h101, 32'h0);
      end_frame();

      #1 check_val("total_frm_err", 64'(n_err), 64'(1));
      check_val("wr_queue_empty", 64'(wr_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
